reg_wb_queue: RTL and testbench
===============================

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 Parameter DW, default 8, register data width.
REQ-002 Parameter AW, default 2, register address width (4 registers; R3 is the stack pointer).
REQ-003 Parameter DEPTH, default 4, pending-write queue depth; power of two.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 mem_valid  in  1  load-result write request.
REQ-007 mem_addr  in  AW  load destination register.
REQ-008 mem_data  in  DW  load data.
REQ-009 mem_ready  out  1  load request accepted when high with mem_valid.
REQ-010 alu_valid  in  1  ALU-result write request.
REQ-011 alu_addr  in  AW  ALU destination register.
REQ-012 alu_data  in  DW  ALU data.
REQ-013 alu_ready  out  1  ALU request accepted when high with alu_valid.
REQ-014 wb_hold  in  1  register-file write port blocked this cycle.
REQ-015 wb_en  out  1  write strobe to the register-file write port.
REQ-016 wb_addr  out  AW  register-file write address.
REQ-017 wb_data  out  DW  register-file write data.
REQ-018 fwd_addr  in  AW  decode-stage lookup address.
REQ-019 fwd_hit  out  1  a pending write to fwd_addr exists.
REQ-020 fwd_data  out  DW  data of the youngest pending write to fwd_addr.
REQ-021 count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-022 The block SHALL hold a FIFO of {addr, data} entries; writes issue to the register file strictly in acceptance order.
REQ-023 mem_ready SHALL be high iff the registered count < DEPTH; a pop in the same cycle is not counted.
REQ-024 alu_ready SHALL be high iff count < DEPTH and not (mem_valid and count == DEPTH-1).
REQ-025 Simultaneous accepted mem and ALU requests SHALL both enqueue in one edge, the mem entry being the older.
REQ-026 wb_en SHALL be high combinationally iff count > 0 and wb_hold is low; wb_addr/wb_data SHALL show the head entry whenever count > 0, and zero when empty.
REQ-027 The head SHALL pop on the rising edge where wb_en is high.
REQ-028 Latency: a request accepted at edge N SHALL appear on wb_* during cycle N+1 when the queue was empty and wb_hold is low.
REQ-029 Simultaneous push(es) and pop SHALL update count by (pushes - 1) with no loss; a push into a full queue SHALL never occur.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH.
REQ-031 fwd_hit/fwd_data SHALL be combinational over all occupied entries, including the head being popped this cycle; the youngest match wins; fwd_data SHALL be zero on a miss.
REQ-032 Entries accepted at the current edge SHALL NOT be visible to forwarding until the following cycle.
REQ-033 wb_hold SHALL stall draining only; acceptance continues until full.

Reset
REQ-034 While rst is high at a rising edge the queue SHALL empty: count=0, pointers=0, wb_en=0, wb_addr=0, wb_data=0, fwd_hit=0.
REQ-035 Reset mid-operation SHALL discard all pending entries without issuing them; requests presented during the reset cycle are dropped and mem_ready/alu_ready reflect count=0 in the next cycle.

Structure
REQ-036 DW, AW, DEPTH defaults and the SP register index (3) SHALL live in a shared processor package.
REQ-037 Storage and pointers SHALL be one sub-module, wb_fifo (2-push/1-pop); arbitration, ready logic and forwarding reside in reg_wb_queue.

Verification
REQ-038 Empty queue, alu_valid with addr=1, data=0x5A -> wb_en=1, wb_addr=1, wb_data=0x5A in the next cycle; count returns to 0.
REQ-039 Same cycle mem(addr=2, 0x11) and alu(addr=2, 0x22), wb_hold=1 -> count=2; fwd_addr=2 gives fwd_hit=1, fwd_data=0x22; releasing hold issues 0x11, then 0x22.
REQ-040 wb_hold=1 and 4 ALU pushes -> count=4, both readies low; count=3 with mem_valid=1 -> alu_ready=0, mem_ready=1.
REQ-041 Full queue, hold released, continuous alu pushes -> one write per cycle, FIFO order preserved across pointer wrap.
REQ-042 Three pending entries, rst asserted for one cycle -> count=0, wb_en=0 next cycle; no discarded entry is ever issued.
REQ-043 fwd_addr=3 with no pending write to R3 -> fwd_hit=0, fwd_data=0x00.

Source files
------------

// File: rtl/reg_wb_queue_pkg.sv
// Shared processor constants for the register write-back queue: default widths,
// queue depth and the stack-pointer register index.
package reg_wb_queue_pkg;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 2;
    localparam int DEPTH_DEF = 4;
    localparam int SP_REG    = 3;

endpackage

// File: rtl/reg_wb_queue_wb_fifo.sv
// Storage and pointers for pending register writes.
// Two pushes and one pop per edge. push0 is always the older entry.
module wb_fifo #(
    parameter int DW    = 8,
    parameter int AW    = 2,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0_i,
    input  logic [AW-1:0]              addr0_i,
    input  logic [DW-1:0]              data0_i,
    input  logic                       push1_i,
    input  logic [AW-1:0]              addr1_i,
    input  logic [DW-1:0]              data1_i,
    input  logic                       pop_i,
    output logic [CW-1:0]              count_o,
    output logic [PW-1:0]              rd_ptr_o,
    output logic [DEPTH-1:0][AW-1:0]   addr_o,
    output logic [DEPTH-1:0][DW-1:0]   data_o
);

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot1;
    logic [CW-1:0]            count_q, count_d;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;

    // The younger push lands one slot further on only when both pushes fire.
    always_comb begin
        slot1    = wr_ptr_q + PW'(push0_i);
        wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push0_i) begin
                addr_q[wr_ptr_q] <= addr0_i;
                data_q[wr_ptr_q] <= data0_i;
            end
            if (push1_i) begin
                addr_q[slot1] <= addr1_i;
                data_q[slot1] <= data1_i;
            end
        end
    end

    assign count_o  = count_q;
    assign rd_ptr_o = rd_ptr_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;

endmodule

// File: rtl/reg_wb_queue.sv
// Register write-back queue: merges load and ALU results into one in-order
// register-file write port, with forwarding of pending writes to decode.
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          wb_hold,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic [CW-1:0] count
);

    logic                     mem_push, alu_push, pop, not_empty;
    logic [PW-1:0]            rd_ptr;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;

    // Loads win the last free slot; a same-cycle pop never frees space early.
    assign mem_ready = count < CW'(DEPTH);
    assign alu_ready = (count < CW'(DEPTH)) && !(mem_valid && count == CW'(DEPTH - 1));
    assign mem_push  = mem_valid && mem_ready;
    assign alu_push  = alu_valid && alu_ready;

    assign not_empty = count != '0;
    assign pop       = not_empty && !wb_hold;
    assign wb_en     = pop;
    assign wb_addr   = not_empty ? ent_addr[rd_ptr] : '0;
    assign wb_data   = not_empty ? ent_data[rd_ptr] : '0;

    wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push0_i  (mem_push),
        .addr0_i  (mem_addr),
        .data0_i  (mem_data),
        .push1_i  (alu_push),
        .addr1_i  (alu_addr),
        .data1_i  (alu_data),
        .pop_i    (pop),
        .count_o  (count),
        .rd_ptr_o (rd_ptr),
        .addr_o   (ent_addr),
        .data_o   (ent_data)
    );

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count && ent_addr[rd_ptr + PW'(k)] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[rd_ptr + PW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized and directed checks of reg_wb_queue against a queue-based model.
module tb_reg_wb_queue;
    import reg_wb_queue_pkg::*;

    localparam int DW    = DW_DEF;
    localparam int AW    = AW_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid, alu_valid, wb_hold;
    logic [AW-1:0] mem_addr, alu_addr, fwd_addr;
    logic [DW-1:0] mem_data, alu_data;
    logic          mem_ready, alu_ready, wb_en, fwd_hit;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data, fwd_data;
    logic [CW-1:0] count;

    reg_wb_queue dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_hold(wb_hold), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int d;} ent_t;
    ent_t q[$];
    int   total = 0;
    int   bad = 0;
    int   e_count, e_wba, e_wbd, e_fd;
    bit   e_mready, e_aready, e_wben, e_hit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        mem_valid = 1'b0; alu_valid = 1'b0; rst = 1'b0;
    endtask

    // Settle inputs, derive every expected output from the pending-write list, compare.
    task automatic pre();
        #1;
        e_count  = q.size();
        e_mready = e_count < DEPTH;
        e_aready = e_count < DEPTH && !(mem_valid && e_count == DEPTH - 1);
        e_wben   = e_count > 0 && !wb_hold;
        e_wba    = e_count > 0 ? q[0].a : 0;
        e_wbd    = e_count > 0 ? q[0].d : 0;
        e_hit    = 1'b0;
        e_fd     = 0;
        foreach (q[i]) if (q[i].a == int'(fwd_addr)) begin e_hit = 1'b1; e_fd = q[i].d; end
        chk("count",     32'(count),     32'(e_count));
        chk("mem_ready", 32'(mem_ready), 32'(e_mready));
        chk("alu_ready", 32'(alu_ready), 32'(e_aready));
        chk("wb_en",     32'(wb_en),     32'(e_wben));
        chk("wb_addr",   32'(wb_addr),   32'(e_wba));
        chk("wb_data",   32'(wb_data),   32'(e_wbd));
        chk("fwd_hit",   32'(fwd_hit),   32'(e_hit));
        chk("fwd_data",  32'(fwd_data),  32'(e_fd));
    endtask

    // Advance the model across one rising edge using the inputs held over it.
    task automatic post();
        bit   mp, ap, rr, pp;
        ent_t me, ae;
        mp = mem_valid && e_mready;
        ap = alu_valid && e_aready;
        rr = rst;
        pp = e_wben;
        me = '{int'(mem_addr), int'(mem_data)};
        ae = '{int'(alu_addr), int'(alu_data)};
        @(posedge clk);
        if (rr) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (mp) q.push_back(me);
            if (ap) q.push_back(ae);
        end
        @(negedge clk);
    endtask

    task automatic alu_push(input int a, input int d);
        idle(); alu_valid = 1'b1; alu_addr = AW'(a); alu_data = DW'(d);
        pre(); post();
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0; wb_hold = 1'b0;
        mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0; fwd_addr = '0;
        @(posedge clk);
        @(negedge clk);
        pre(); post();

        // Reset state
        idle(); pre();
        chk("rst_count", 32'(count), 0);
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_fwd_hit", 32'(fwd_hit), 0);
        post();

        // Single ALU write, one-cycle latency
        alu_push(1, 8'h5A);
        idle(); pre();
        chk("lat_wb_en", 32'(wb_en), 1);
        chk("lat_wb_addr", 32'(wb_addr), 1);
        chk("lat_wb_data", 32'(wb_data), 32'h5A);
        post();
        pre(); chk("lat_count0", 32'(count), 0); post();

        // Dual push under hold, youngest forwards, drain in order
        wb_hold = 1'b1;
        mem_valid = 1'b1; mem_addr = 2; mem_data = 8'h11;
        alu_valid = 1'b1; alu_addr = 2; alu_data = 8'h22;
        pre(); post();
        idle(); fwd_addr = 2; pre();
        chk("dual_count", 32'(count), 2);
        chk("dual_fwd_hit", 32'(fwd_hit), 1);
        chk("dual_fwd_data", 32'(fwd_data), 32'h22);
        post();
        wb_hold = 1'b0;
        pre(); chk("dual_first", 32'(wb_data), 32'h11); post();
        pre(); chk("dual_second", 32'(wb_data), 32'h22); post();

        // SP lookup with no pending SP write, then fill to full
        wb_hold = 1'b1;
        alu_push(1, 8'h33);
        idle(); fwd_addr = AW'(SP_REG); pre();
        chk("sp_fwd_hit", 32'(fwd_hit), 0);
        chk("sp_fwd_data", 32'(fwd_data), 0);
        post();
        alu_push(0, 8'h44);
        alu_push(2, 8'h55);
        mem_valid = 1'b1; mem_addr = 3; mem_data = 8'h66;
        alu_valid = 1'b1; alu_addr = 0; alu_data = 8'h77;
        pre();
        chk("cnt3_alu_ready", 32'(alu_ready), 0);
        chk("cnt3_mem_ready", 32'(mem_ready), 1);
        post();
        idle(); pre();
        chk("full_count", 32'(count), 4);
        chk("full_mem_ready", 32'(mem_ready), 0);
        chk("full_alu_ready", 32'(alu_ready), 0);
        chk("full_fwd_sp", 32'(fwd_data), 32'h66);
        post();

        // Release from full with continuous ALU pushes across the wrap
        wb_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle(); alu_valid = 1'b1; alu_addr = AW'(i); alu_data = DW'(8'h80 + i);
            pre();
            if (i == 0) chk("wrap_first", 32'(wb_data), 32'h33);
            chk("wrap_wb_en", 32'(wb_en), 1);
            post();
        end
        idle();
        for (int i = 0; i < 6; i++) begin pre(); post(); end

        // Reset with three pending entries and live requests
        wb_hold = 1'b1;
        alu_push(1, 8'hA1);
        alu_push(2, 8'hA2);
        alu_push(0, 8'hA3);
        rst = 1'b1; mem_valid = 1'b1; alu_valid = 1'b1;
        pre(); post();
        idle(); wb_hold = 1'b0; pre();
        chk("rst3_count", 32'(count), 0);
        chk("rst3_wb_en", 32'(wb_en), 0);
        chk("rst3_mem_ready", 32'(mem_ready), 1);
        chk("rst3_alu_ready", 32'(alu_ready), 1);
        post();

        // Random traffic, alternating light and heavy hold to reach full often
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            mem_valid = 1'($urandom_range(0, 1));
            alu_valid = 1'($urandom_range(0, 1));
            mem_addr  = AW'($urandom);
            alu_addr  = AW'($urandom);
            mem_data  = DW'($urandom);
            alu_data  = DW'($urandom);
            fwd_addr  = AW'($urandom);
            wb_hold   = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            pre(); post();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
